// File: rtl/lcd_scan_ctrl_if.sv
// Control/status bundle between the view-select controller and its user (buttons, mode inputs, mux select).
// Pure wiring; no latency, no backpressure.
interface lcd_scan_ctrl_if;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic       hold;
    logic [4:0] slct;
    logic [3:0] idx;
    logic       chg;

    modport master (
        output btn_next, btn_prev, auto_en, hold,
        input  slct, idx, chg
    );

    modport slave (
        input  btn_next, btn_prev, auto_en, hold,
        output slct, idx, chg
    );
endinterface

// File: rtl/lcd_scan_ctrl.sv
// LCD view scanner: 15-entry view table stepped by synchronized buttons or a dwell timer in auto mode.
// Button to IDX/SLCT/CHG latency is 2 edges after first sample; no backpressure, steps are never queued.
module lcd_scan_ctrl #(
    parameter int unsigned DWELL = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_scan_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [25:0] TERM     = 26'(DWELL - 1);
    localparam logic [3:0]  LAST_IDX = 4'd14;

    logic        nxt_s1, nxt_s2, nxt_e;
    logic        prv_s1, prv_s2, prv_e;
    logic [1:0]  fill_q;
    logic        armed;
    logic        rise_nxt, rise_prv;
    logic        step_nxt, step_prv;

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [25:0] cnt_base;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  slct_q;
    logic        chg_q, chg_d;
    logic        advance;

    function automatic logic [4:0] view_code(input logic [3:0] i);
        logic [4:0] c;
        case (i)
            4'd0:    c = 5'b00000;
            4'd1:    c = 5'b00001;
            4'd2:    c = 5'b00010;
            4'd3:    c = 5'b00100;
            4'd4:    c = 5'b01000;
            4'd5:    c = 5'b10000;
            4'd6:    c = 5'b00011;
            4'd7:    c = 5'b00110;
            4'd8:    c = 5'b01100;
            4'd9:    c = 5'b00111;
            4'd10:   c = 5'b01110;
            4'd11:   c = 5'b11100;
            4'd12:   c = 5'b01111;
            4'd13:   c = 5'b11110;
            4'd14:   c = 5'b11111;
            default: c = 5'b00000;
        endcase
        return c;
    endfunction

    // Edge FFs track sync FF2 unconditionally; steps are gated off until the
    // pipeline has refilled after reset so a held button cannot fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_s1 <= 1'b0; nxt_s2 <= 1'b0; nxt_e <= 1'b0;
            prv_s1 <= 1'b0; prv_s2 <= 1'b0; prv_e <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            nxt_s1 <= bus.btn_next; nxt_s2 <= nxt_s1; nxt_e <= nxt_s2;
            prv_s1 <= bus.btn_prev; prv_s2 <= prv_s1; prv_e <= prv_s2;
            if (fill_q != 2'd3)
                fill_q <= fill_q + 2'd1;
        end
    end

    assign armed    = (fill_q == 2'd3);
    assign rise_nxt = nxt_s2 & ~nxt_e;
    assign rise_prv = prv_s2 & ~prv_e;
    assign step_nxt = armed & rise_nxt & ~rise_prv;
    assign step_prv = armed & rise_prv & ~rise_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            cnt_q   <= 26'd0;
            idx_q   <= 4'd0;
            slct_q  <= 5'b00000;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            slct_q  <= view_code(idx_d);
            chg_q   <= chg_d;
        end
    end

    // Mode follows the inputs combinationally so the first auto edge already counts.
    always_comb begin
        state_d  = MANUAL;
        cnt_d    = cnt_q;
        cnt_base = cnt_q;
        idx_d    = idx_q;
        advance  = 1'b0;
        chg_d    = 1'b0;

        if (bus.auto_en)
            state_d = bus.hold ? PAUSED : AUTO;

        case (state_d)
            AUTO: begin
                if (state_q == MANUAL)
                    cnt_base = 26'd0;
                if (cnt_base == TERM) begin
                    advance = 1'b1;
                    cnt_d   = 26'd0;
                end else begin
                    cnt_d = cnt_base + 26'd1;
                end
            end
            PAUSED:  cnt_d = (state_q == MANUAL) ? 26'd0 : cnt_q;
            default: cnt_d = 26'd0;
        endcase

        if (step_nxt || advance)
            idx_d = (idx_q >= LAST_IDX) ? 4'd0 : idx_q + 4'd1;
        if (step_prv)
            idx_d = (idx_q == 4'd0 || idx_q > LAST_IDX) ? LAST_IDX : idx_q - 4'd1;
        if (step_nxt || step_prv)
            cnt_d = 26'd0;
        if (idx_q > LAST_IDX)
            idx_d = 4'd0;

        chg_d = (idx_d != idx_q);
    end

    assign bus.idx  = idx_q;
    assign bus.slct = slct_q;
    assign bus.chg  = chg_q;

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Directed bench for lcd_scan_ctrl: one DUT with DWELL=4, one with DWELL=1.
module tb_lcd_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lcd_scan_ctrl_if ifa();
    lcd_scan_ctrl_if ifb();

    lcd_scan_ctrl #(.DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    lcd_scan_ctrl #(.DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs;
        ifa.btn_next = 1'b0; ifa.btn_prev = 1'b0; ifa.auto_en = 1'b0; ifa.hold = 1'b0;
        ifb.btn_next = 1'b0; ifb.btn_prev = 1'b0; ifb.auto_en = 1'b0; ifb.hold = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_reset;
        idle_inputs();
        ifa.btn_next = 1'b1; ifa.auto_en = 1'b1; ifb.auto_en = 1'b1;
        rst = 1'b1;
        tick(3);
        total++; if (ifa.idx !== 4'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", ifa.idx); end
        total++; if (ifa.slct !== 5'b00000) begin bad++; $display("FAIL reset_slct: got %b want 00000", ifa.slct); end
        total++; if (ifa.chg !== 1'b0) begin bad++; $display("FAIL reset_chg: got %b want 0", ifa.chg); end
        total++; if (ifb.idx !== 4'd0 || ifb.chg !== 1'b0) begin bad++; $display("FAIL reset_b: got idx=%0d chg=%b want 0/0", ifb.idx, ifb.chg); end
        idle_inputs();
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_manual_next;
        logic [3:0] exp_idx [3];
        logic [4:0] exp_slct [3];
        exp_idx  = '{4'd1, 4'd2, 4'd3};
        exp_slct = '{5'b00001, 5'b00010, 5'b00100};
        for (int i = 0; i < 3; i++) begin
            ifa.btn_next = 1'b1;
            tick(2);
            total++;
            if (ifa.chg !== 1'b0 || ifa.idx !== 4'(i)) begin
                bad++; $display("FAIL next_early%0d: got idx=%0d chg=%b want idx=%0d chg=0", i, ifa.idx, ifa.chg, i);
            end
            tick(1);
            total++;
            if (ifa.idx !== exp_idx[i] || ifa.slct !== exp_slct[i] || ifa.chg !== 1'b1) begin
                bad++; $display("FAIL next_step%0d: got idx=%0d slct=%b chg=%b want idx=%0d slct=%b chg=1",
                                i, ifa.idx, ifa.slct, ifa.chg, exp_idx[i], exp_slct[i]);
            end
            tick(1);
            total++; if (ifa.chg !== 1'b0) begin bad++; $display("FAIL next_chg_pulse%0d: got %b want 0", i, ifa.chg); end
            ifa.btn_next = 1'b0;
            tick(3);
        end
    endtask

    task automatic test_prev_wrap;
        do_reset();
        ifa.btn_prev = 1'b1;
        tick(3);
        total++;
        if (ifa.idx !== 4'd14 || ifa.slct !== 5'b11111 || ifa.chg !== 1'b1) begin
            bad++; $display("FAIL prev_wrap: got idx=%0d slct=%b chg=%b want 14 11111 1", ifa.idx, ifa.slct, ifa.chg);
        end
        ifa.btn_prev = 1'b0;
        tick(3);
        ifa.btn_next = 1'b1;
        tick(3);
        total++;
        if (ifa.idx !== 4'd0 || ifa.slct !== 5'b00000 || ifa.chg !== 1'b1) begin
            bad++; $display("FAIL next_wrap: got idx=%0d slct=%b chg=%b want 0 00000 1", ifa.idx, ifa.slct, ifa.chg);
        end
        ifa.btn_next = 1'b0;
        tick(3);
    endtask

    task automatic test_auto;
        int nchg;
        do_reset();
        nchg = 0;
        ifa.auto_en = 1'b1;
        for (int t = 1; t <= 64; t++) begin
            tick(1);
            nchg += int'(ifa.chg);
            if (t == 4) begin
                total++; if (ifa.idx !== 4'd1 || ifa.slct !== 5'b00001) begin bad++; $display("FAIL auto_first: got idx=%0d slct=%b want 1 00001", ifa.idx, ifa.slct); end
            end
            if (t == 59) begin
                total++; if (ifa.idx !== 4'd14) begin bad++; $display("FAIL auto_t59: got %0d want 14", ifa.idx); end
            end
            if (t == 60) begin
                total++; if (ifa.idx !== 4'd0 || ifa.chg !== 1'b1) begin bad++; $display("FAIL auto_wrap: got idx=%0d chg=%b want 0 1", ifa.idx, ifa.chg); end
            end
        end
        total++; if (nchg != 16) begin bad++; $display("FAIL auto_chg_count: got %0d want 16", nchg); end
        total++; if (ifa.idx !== 4'd1) begin bad++; $display("FAIL auto_t64: got %0d want 1", ifa.idx); end
    endtask

    task automatic test_hold;
        int nchg;
        tick(2);
        ifa.hold = 1'b1;
        nchg = 0;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            nchg += int'(ifa.chg);
        end
        total++; if (nchg != 0 || ifa.idx !== 4'd1) begin bad++; $display("FAIL hold_frozen: got chg=%0d idx=%0d want 0 1", nchg, ifa.idx); end
        ifa.hold = 1'b0;
        tick(1);
        total++; if (ifa.chg !== 1'b0 || ifa.idx !== 4'd1) begin bad++; $display("FAIL hold_resume1: got chg=%b idx=%0d want 0 1", ifa.chg, ifa.idx); end
        tick(1);
        total++; if (ifa.chg !== 1'b1 || ifa.idx !== 4'd2) begin bad++; $display("FAIL hold_resume2: got chg=%b idx=%0d want 1 2", ifa.chg, ifa.idx); end
    endtask

    task automatic test_auto_button;
        ifa.btn_next = 1'b1;
        tick(3);
        total++; if (ifa.chg !== 1'b1 || ifa.idx !== 4'd3) begin bad++; $display("FAIL auto_btn_step: got chg=%b idx=%0d want 1 3", ifa.chg, ifa.idx); end
        ifa.btn_next = 1'b0;
        tick(3);
        total++; if (ifa.idx !== 4'd3) begin bad++; $display("FAIL auto_btn_cnt_clear: got %0d want 3", ifa.idx); end
        tick(1);
        total++; if (ifa.chg !== 1'b1 || ifa.idx !== 4'd4) begin bad++; $display("FAIL auto_btn_next_adv: got chg=%b idx=%0d want 1 4", ifa.chg, ifa.idx); end
    endtask

    task automatic test_cancel_and_long;
        int nchg;
        do_reset();
        nchg = 0;
        ifa.btn_next = 1'b1; ifa.btn_prev = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            nchg += int'(ifa.chg);
        end
        total++; if (nchg != 0 || ifa.idx !== 4'd0) begin bad++; $display("FAIL cancel: got chg=%0d idx=%0d want 0 0", nchg, ifa.idx); end
        idle_inputs();
        tick(3);
        nchg = 0;
        ifa.btn_next = 1'b1;
        for (int t = 0; t < 100; t++) begin
            tick(1);
            nchg += int'(ifa.chg);
        end
        total++; if (nchg != 1 || ifa.idx !== 4'd1) begin bad++; $display("FAIL long_hold: got chg=%0d idx=%0d want 1 1", nchg, ifa.idx); end
        ifa.btn_next = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid;
        int nchg;
        do_reset();
        ifa.btn_next = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        nchg = 0;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            nchg += int'(ifa.chg);
        end
        ifa.btn_next = 1'b0;
        tick(3);
        total++; if (nchg != 0 || ifa.idx !== 4'd0) begin bad++; $display("FAIL reset_mid: got chg=%0d idx=%0d want 0 0", nchg, ifa.idx); end
    endtask

    task automatic test_dwell1;
        int nchg;
        do_reset();
        ifb.auto_en = 1'b1;
        tick(1);
        total++; if (ifb.idx !== 4'd1 || ifb.chg !== 1'b1) begin bad++; $display("FAIL dwell1_first: got idx=%0d chg=%b want 1 1", ifb.idx, ifb.chg); end
        nchg = 0;
        for (int t = 0; t < 14; t++) begin
            tick(1);
            nchg += int'(ifb.chg);
        end
        total++; if (nchg != 14 || ifb.idx !== 4'd0 || ifb.slct !== 5'b00000) begin
            bad++; $display("FAIL dwell1_run: got chg=%0d idx=%0d slct=%b want 14 0 00000", nchg, ifb.idx, ifb.slct);
        end
        ifb.auto_en = 1'b0;
        tick(1);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_manual_next();
        test_prev_wrap();
        test_auto();
        test_hold();
        test_auto_button();
        test_cancel_and_long();
        test_reset_mid();
        test_dwell1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_scan_ctrl.md
LCD_SCAN_CTRL -- requirements
Module: lcd_scan_ctrl

Interface
REQ-001 The parameter DWELL SHALL be declared with default 50000000; it is the number of CLK cycles each view is shown in auto mode (legal range 1..2^26-1).
REQ-002 The port CLK SHALL be an input, 1 bit wide, and is the single system clock; all state updates on its rising edge.
REQ-003 The port RST SHALL be an input, 1 bit wide, and is the reset; reset is synchronous and active-high.
REQ-004 The port BTN_NEXT SHALL be an input, 1 bit wide, and is a raw, asynchronous, debounced level request to step to the next view.
REQ-005 The port BTN_PREV SHALL be an input, 1 bit wide, and is a raw, asynchronous, debounced level request to step to the previous view.
REQ-006 The port AUTO_EN SHALL be an input, 1 bit wide, that selects auto-scan mode when 1 and manual mode when 0.
REQ-007 The port HOLD SHALL be an input, 1 bit wide, that freezes the dwell counter while 1 in auto mode.
REQ-008 The port SLCT SHALL be an output, 5 bits wide, and is the registered display-select code driven to the LCD view mux.
REQ-009 The port IDX SHALL be an output, 4 bits wide, and is the registered current view index (0..14).
REQ-010 The port CHG SHALL be an output, 1 bit wide, that pulses high for exactly one cycle in the cycle where SLCT/IDX take a new value.

Function
REQ-011 View table, index->SLCT: 0:00000, 1:00001, 2:00010, 3:00100, 4:01000, 5:10000, 6:00011, 7:00110, 8:01100, 9:00111, 10:01110, 11:11100, 12:01111, 13:11110, 14:11111.
REQ-012 SLCT SHALL always equal table(IDX); both registered, updated on the same edge.
REQ-013 BTN_NEXT and BTN_PREV SHALL each pass through a 2-FF synchronizer, followed by a rising-edge detector (third FF); one step per 0->1 transition, regardless of hold duration.
REQ-014 Latency: a button first sampled high at edge k SHALL produce the new IDX/SLCT and CHG=1 after edge k+2.
REQ-015 Next step: IDX+1; 14 wraps to 0. Prev step: IDX-1; 0 wraps to 14.
REQ-016 Next and prev edges detected in the same cycle SHALL cancel: no index change, no CHG, dwell counter unaffected.
REQ-017 State machine states: MANUAL, AUTO, PAUSED; AUTO_EN=0 -> MANUAL; AUTO_EN=1 & HOLD=0 -> AUTO; AUTO_EN=1 & HOLD=1 -> PAUSED; state registered, evaluated every cycle.
REQ-018 MANUAL: dwell counter held at 0; only buttons change IDX.
REQ-019 AUTO: 26-bit dwell counter increments each cycle; when count==DWELL-1, IDX advances (as next step), counter returns to 0, CHG pulses.
REQ-020 PAUSED: counter holds its value; buttons still step; on return to AUTO counting resumes from held value.
REQ-021 Button step in AUTO or PAUSED SHALL reset the counter to 0; if a button step and dwell terminal coincide, only the button step applies (single step, counter to 0).
REQ-022 Transition MANUAL->AUTO SHALL start the counter at 0; AUTO/PAUSED->MANUAL SHALL clear it to 0.
REQ-023 DWELL=1 SHALL advance IDX every cycle in AUTO with CHG held high continuously.
REQ-024 IDX SHALL never take values 15; any such value (unreachable) SHALL map to index 0 on the next edge.

Reset
REQ-025 While RST=1 at a rising edge: IDX=0, SLCT=00000, CHG=0, counter=0, synchronizer/edge FFs=0, state=MANUAL; RST dominates all inputs.
REQ-026 A button held high through reset release SHALL NOT generate a step (edge FFs cleared to 0 are treated as already-seen only after sync fill; first step requires a fresh 0->1 after release... implementation: edge FF loaded from sync FF2 during first two post-reset cycles, no step issued).
REQ-027 Reset mid-dwell or mid-synchronization SHALL discard the pending step or advance.

Verification
REQ-028 Reset, MANUAL, pulse BTN_NEXT 3 separate times -> IDX 1,2,3; SLCT 00001,00010,00100; one CHG per step, each 2 edges after first high sample.
REQ-029 IDX=0, pulse BTN_PREV -> IDX=14, SLCT=11111; then BTN_NEXT -> IDX=0, SLCT=00000.
REQ-030 DWELL=4, AUTO_EN=1 for 64 cycles -> IDX advances every 4 cycles, wraps 14->0 after 60 cycles, 16 CHG pulses.
REQ-031 DWELL=4, AUTO; HOLD=1 for 10 cycles at count 2 -> no change during hold; after release advance occurs 2 cycles later.
REQ-032 BTN_NEXT and BTN_PREV rising same cycle -> IDX unchanged, CHG=0; BTN_NEXT held 100 cycles -> exactly one step.
REQ-033 RST asserted one cycle after BTN_NEXT rises -> IDX stays 0, no CHG after release.
